// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single shared ALU.
// One operation in flight; the result is held until the granted requester consumes it.
module alu_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [4:0]  req_instr0,
    input  logic [4:0]  req_instr1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_s,
    output logic        rsp_ze,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_instr,
    input  logic [31:0] alu_s,
    input  logic        alu_ze,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        gnt_q, gnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  instr_q, instr_d;
    logic [31:0] s_q, s_d;
    logic        ze_q, ze_d;
    logic        gnt_idx;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        instr_d   = instr_q;
        s_d       = s_q;
        ze_d      = ze_q;
        req_ready = 2'b00;
        // The round-robin pointer only breaks ties; a lone requester always wins.
        gnt_idx   = (req_valid == 2'b11) ? rr_q : req_valid[1];

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready = gnt_idx ? 2'b10 : 2'b01;
                    state_d   = EXEC;
                    gnt_d     = gnt_idx;
                    rr_d      = ~gnt_idx;
                    cnt_d     = CNT_LOAD;
                    a_d       = gnt_idx ? req_a1 : req_a0;
                    b_d       = gnt_idx ? req_b1 : req_b0;
                    instr_d   = gnt_idx ? req_instr1 : req_instr0;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    s_d     = alu_s;
                    ze_d    = alu_ze;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            instr_q <= 5'd0;
            s_q     <= 32'd0;
            ze_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            instr_q <= instr_d;
            s_q     <= s_d;
            ze_q    <= ze_d;
        end
    end

    // ALU operands come only from registers, so they never glitch with requester inputs.
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_instr = {27'd0, instr_q};
    assign rsp_s     = s_q;
    assign rsp_ze    = ze_q;
    assign rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (LATENCY 1 and 4) driven from a
// transaction-level model of arbitration, latency and result hand-off.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic [1:0]  req_valid  [2];
    logic [1:0]  req_ready  [2];
    logic [31:0] req_a0     [2];
    logic [31:0] req_b0     [2];
    logic [31:0] req_a1     [2];
    logic [31:0] req_b1     [2];
    logic [4:0]  req_instr0 [2];
    logic [4:0]  req_instr1 [2];
    logic [1:0]  rsp_valid  [2];
    logic [1:0]  rsp_ready  [2];
    logic [31:0] rsp_s      [2];
    logic        rsp_ze     [2];
    logic [31:0] alu_a      [2];
    logic [31:0] alu_b      [2];
    logic [31:0] alu_instr  [2];
    logic [32:0] alu_res    [2];
    logic        busy       [2];

    // Stand-in ALU: integer ops by opcode, float "add" of equal values doubles via exponent+1.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] ins);
        logic [31:0] s;
        case (ins[2:0])
            3'd0:    s = ins[3] ? ((a == b) ? a + 32'h0080_0000 : a ^ b) : a + b;
            3'd1:    s = a - b;
            3'd2:    s = a & b;
            3'd3:    s = a * b;
            3'd4:    s = a | b;
            3'd5:    s = a ^ b;
            3'd6:    s = a << b[4:0];
            default: s = ins[4] ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
        endcase
        return {(s == 32'd0), s};
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            assign alu_res[gi] = alu_ref(alu_a[gi], alu_b[gi], alu_instr[gi][4:0]);
            alu_arbiter #(.LATENCY(gi == 0 ? 1 : 4)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n[gi]),
                .req_valid  (req_valid[gi]),
                .req_ready  (req_ready[gi]),
                .req_a0     (req_a0[gi]),
                .req_b0     (req_b0[gi]),
                .req_a1     (req_a1[gi]),
                .req_b1     (req_b1[gi]),
                .req_instr0 (req_instr0[gi]),
                .req_instr1 (req_instr1[gi]),
                .rsp_valid  (rsp_valid[gi]),
                .rsp_ready  (rsp_ready[gi]),
                .rsp_s      (rsp_s[gi]),
                .rsp_ze     (rsp_ze[gi]),
                .alu_a      (alu_a[gi]),
                .alu_b      (alu_b[gi]),
                .alu_instr  (alu_instr[gi]),
                .alu_s      (alu_res[gi][31:0]),
                .alu_ze     (alu_res[gi][32]),
                .busy       (busy[gi])
            );
        end
    endgenerate

    int n_cmp;
    int n_bad;
    int edge_n;
    int cur_lat;

    // Reference model state: pending requests, in-flight op, last captured operands.
    bit          pend [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [4:0]  pi [2];
    bit          infl;
    int          infl_port;
    logic [32:0] infl_res;
    int          rsp_from;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [4:0]  last_i;
    int          rr;
    int          served_port [$];
    logic [32:0] served_res  [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s lat=%0d got=%h expected=%h t=%0t", tag, cur_lat, got, exp, $time);
        end
    endtask

    task automatic set_req(input int inst, input int p, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] ins);
        pend[p] = 1'b1;
        pa[p]   = a;
        pb[p]   = b;
        pi[p]   = ins;
    endtask

    task automatic do_reset(input int inst);
        req_valid[inst] = 2'b00;
        rsp_ready[inst] = 2'b00;
        rst_n[inst]     = 1'b0;
        #1;
        chk_eq("rst_busy",      32'(busy[inst]),      32'd0);
        chk_eq("rst_rsp_valid", 32'(rsp_valid[inst]), 32'd0);
        chk_eq("rst_rsp_s",     rsp_s[inst],          32'd0);
        chk_eq("rst_rsp_ze",    32'(rsp_ze[inst]),    32'd0);
        chk_eq("rst_alu_a",     alu_a[inst],          32'd0);
        chk_eq("rst_alu_b",     alu_b[inst],          32'd0);
        chk_eq("rst_alu_instr", alu_instr[inst],      32'd0);
        infl    = 1'b0;
        rr      = 0;
        last_a  = 32'd0;
        last_b  = 32'd0;
        last_i  = 5'd0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        served_port.delete();
        served_res.delete();
        @(negedge clk);
        rst_n[inst] = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance the model at posedge.
    task automatic step(input int inst, input bit rnd, input logic [1:0] rdy);
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        int         g;
        if (rnd) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom % 3 == 0)) begin
                    pa[p] = $urandom;
                    pb[p] = ($urandom % 4 == 0) ? pa[p] : $urandom;
                    pi[p] = 5'($urandom);
                    pend[p] = 1'b1;
                end else if (pend[p] && ($urandom % 16 == 0)) begin
                    pend[p] = 1'b0;
                end
            end
        end
        req_valid[inst]  = {pend[1], pend[0]};
        req_a0[inst]     = pa[0];
        req_b0[inst]     = pb[0];
        req_instr0[inst] = pi[0];
        req_a1[inst]     = pa[1];
        req_b1[inst]     = pb[1];
        req_instr1[inst] = pi[1];
        rsp_ready[inst]  = rnd ? 2'($urandom) : rdy;
        #1;
        g = (pend[0] && pend[1]) ? rr : (pend[1] ? 1 : 0);
        exp_rdy = (!infl && (pend[0] || pend[1])) ? 2'(1 << g) : 2'b00;
        exp_rv  = (infl && edge_n >= rsp_from) ? 2'(1 << infl_port) : 2'b00;
        chk_eq("req_ready", 32'(req_ready[inst]), 32'(exp_rdy));
        chk_eq("rsp_valid", 32'(rsp_valid[inst]), 32'(exp_rv));
        chk_eq("busy",      32'(busy[inst]),      32'(infl));
        chk_eq("alu_a",     alu_a[inst],          last_a);
        chk_eq("alu_b",     alu_b[inst],          last_b);
        chk_eq("alu_instr", alu_instr[inst],      32'(last_i));
        if (exp_rv != 2'b00) begin
            chk_eq("rsp_s",  rsp_s[inst],       infl_res[31:0]);
            chk_eq("rsp_ze", 32'(rsp_ze[inst]), 32'(infl_res[32]));
        end
        @(posedge clk);
        edge_n++;
        if (exp_rdy != 2'b00) begin
            infl      = 1'b1;
            infl_port = g;
            infl_res  = alu_ref(pa[g], pb[g], pi[g]);
            rsp_from  = edge_n + cur_lat;
            last_a    = pa[g];
            last_b    = pb[g];
            last_i    = pi[g];
            rr        = 1 - g;
            pend[g]   = 1'b0;
        end else if (exp_rv != 2'b00 && rsp_ready[inst][infl_port]) begin
            infl = 1'b0;
            served_port.push_back(infl_port);
            served_res.push_back(infl_res);
        end
        @(negedge clk);
    endtask

    task automatic chk_served(input string tag, input int idx, input int port,
                              input logic [31:0] s, input logic ze);
        if (idx < served_port.size()) begin
            chk_eq({tag, "_port"}, 32'(served_port[idx]), 32'(port));
            chk_eq({tag, "_s"},    served_res[idx][31:0], s);
            chk_eq({tag, "_ze"},   32'(served_res[idx][32]), 32'(ze));
        end
    endtask

    task automatic run_inst(input int inst);
        cur_lat = (inst == 0) ? 1 : 4;

        // Single add on port 0.
        do_reset(inst);
        set_req(inst, 0, 32'd5, 32'd2, 5'b00000);
        repeat (cur_lat + 3) step(inst, 1'b0, 2'b11);
        chk_eq("add_count", 32'(served_port.size()), 32'd1);
        chk_served("add", 0, 0, 32'd7, 1'b0);

        // Simultaneous requests alternate between ports.
        do_reset(inst);
        set_req(inst, 0, 32'd5, 32'd2, 5'b00001);
        set_req(inst, 1, 32'd5, 32'd2, 5'b00011);
        repeat (2 * (cur_lat + 2) + 2) step(inst, 1'b0, 2'b11);
        set_req(inst, 0, 32'd5, 32'd2, 5'b00001);
        set_req(inst, 1, 32'd5, 32'd2, 5'b00011);
        repeat (2 * (cur_lat + 2) + 2) step(inst, 1'b0, 2'b11);
        chk_eq("rr_count", 32'(served_port.size()), 32'd4);
        chk_served("rr0", 0, 0, 32'd3, 1'b0);
        chk_served("rr1", 1, 1, 32'd10, 1'b0);
        chk_served("rr2", 2, 0, 32'd3, 1'b0);
        chk_served("rr3", 3, 1, 32'd10, 1'b0);

        // Zero result on port 1.
        do_reset(inst);
        set_req(inst, 1, 32'd5, 32'd5, 5'b00001);
        repeat (cur_lat + 3) step(inst, 1'b0, 2'b11);
        chk_eq("zero_count", 32'(served_port.size()), 32'd1);
        chk_served("zero", 0, 1, 32'd0, 1'b1);

        // Float op with back-pressure; port 1's rsp_ready must be ignored while port 0 owns the result.
        do_reset(inst);
        set_req(inst, 0, 32'h3F00_0000, 32'h3F00_0000, 5'b01000);
        set_req(inst, 1, 32'd7, 32'd3, 5'b00000);
        repeat (cur_lat + 4) step(inst, 1'b0, 2'b10);
        repeat (cur_lat + 6) step(inst, 1'b0, 2'b11);
        chk_eq("flt_count", 32'(served_port.size()), 32'd2);
        chk_served("flt", 0, 0, 32'h3F80_0000, 1'b0);
        chk_served("flt_next", 1, 1, 32'd10, 1'b0);

        // Reset while an op is executing: it must vanish.
        do_reset(inst);
        set_req(inst, 0, 32'd9, 32'd4, 5'b00001);
        step(inst, 1'b0, 2'b11);
        do_reset(inst);
        repeat (cur_lat + 3) step(inst, 1'b0, 2'b11);
        chk_eq("abort_count", 32'(served_port.size()), 32'd0);
        set_req(inst, 1, 32'd10, 32'd3, 5'b00011);
        repeat (cur_lat + 3) step(inst, 1'b0, 2'b11);
        chk_eq("after_abort_count", 32'(served_port.size()), 32'd1);
        chk_served("after_abort", 0, 1, 32'd30, 1'b0);

        // Randomized traffic with random back-pressure and request withdrawal.
        do_reset(inst);
        repeat (300) step(inst, 1'b1, 2'b00);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        edge_n  = 0;
        cur_lat = 1;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]      = 1'b0;
            req_valid[i]  = 2'b00;
            rsp_ready[i]  = 2'b00;
            req_a0[i]     = 32'd0;
            req_b0[i]     = 32'd0;
            req_a1[i]     = 32'd0;
            req_b1[i]     = 32'd0;
            req_instr0[i] = 5'd0;
            req_instr1[i] = 5'd0;
            pend[i]       = 1'b0;
            pa[i]         = 32'd0;
            pb[i]         = 32'd0;
            pi[i]         = 5'd0;
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int inst = 0; inst < 2; inst++) begin
            run_inst(inst);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, ALU settle cycles held before result capture (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  2  per-requester operation request (bit i = port i).
REQ-005 Port: req_ready  output  2  per-requester accept; request accepted when valid and ready are both high at a rising edge.
REQ-006 Port: req_a0, req_b0, req_a1, req_b1  input  32 each  operands for port 0 and port 1.
REQ-007 Port: req_instr0, req_instr1  input  5 each  ALU opcode; bit4 signed, bit3 float, bits[2:0] operation.
REQ-008 Port: rsp_valid  output  2  per-requester result valid.
REQ-009 Port: rsp_ready  input  2  per-requester result consume.
REQ-010 Port: rsp_s  output  32  result word, shared by both ports, meaningful only while a rsp_valid bit is high.
REQ-011 Port: rsp_ze  output  1  ALU zero flag captured with rsp_s.
REQ-012 Port: alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-013 Port: alu_instr  output  32  ALU instruction; bits[4:0] = captured opcode, bits[31:5] = 0.
REQ-014 Port: alu_s  input  32  and  alu_ze  input  1  ALU result and zero flag.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; at most one operation in flight.
REQ-017 IDLE: req_ready SHALL be high for exactly the granted port (combinational from req_valid and rr pointer), 2'b00 if no request; req_ready SHALL be 2'b00 in EXEC and RESP.
REQ-018 Grant: only one valid -> that port; both valid -> port named by rr pointer.
REQ-019 On accept edge: operands and opcode registered, grant index stored, rr pointer set to the other port, cycle counter loaded with LATENCY-1, state -> EXEC.
REQ-020 EXEC: alu_a/alu_b/alu_instr SHALL hold registered values stable; counter decrements each edge.
REQ-021 At the edge where counter is 0 in EXEC: alu_s and alu_ze registered into rsp_s/rsp_ze, state -> RESP; acceptance edge k yields rsp_valid high from edge k+LATENCY.
REQ-022 RESP: rsp_valid bit of granted port high, other bit low; rsp_s/rsp_ze stable until consumed.
REQ-023 On edge with rsp_valid and matching rsp_ready high: state -> IDLE; new request accepted no earlier than the following edge.
REQ-024 rsp_ready of the non-granted port SHALL be ignored; req_valid dropped before accept SHALL cause no grant and no rr change.
REQ-025 In IDLE, alu_a/alu_b/alu_instr SHALL hold last registered values (no combinational pass-through).
REQ-026 Block SHALL not interpret opcodes; all ALU semantics (int, signed, float) pass through unmodified.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, rr pointer 0, counter 0, all operand/opcode/result registers 0, rsp_valid 2'b00, busy 0.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued after release.
REQ-029 First edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-030 LATENCY=1; port0 a=5, b=2, instr=5'b00000 -> req_ready=2'b01, rsp_valid=2'b01 one edge after accept, rsp_s=7, rsp_ze=0.
REQ-031 After reset, both ports valid same cycle (port0 5-2 op 00001, port1 5*2 op 00011) -> port0 served first (rsp_s=3), then port1 (rsp_s=10); next simultaneous pair -> port0 again (pointer alternates).
REQ-032 Port1 a=b=5, instr=00001 -> rsp_s=0, rsp_ze=1, rsp_valid=2'b10.
REQ-033 LATENCY=4; float add a=b=0x3F000000, instr=01000 -> alu inputs stable 4 cycles, rsp_s=0x3F800000; rsp_ready held low 3 cycles -> rsp_s stable, req_ready=2'b00, busy=1.
REQ-034 rst_n pulsed low mid-EXEC -> all outputs 0 asynchronously, no rsp_valid after release, next request served normally.
